// File: rtl/pdm_tone_gen.sv
// pdm_tone_gen: multi-channel NCO tone synthesiser mixed into a 1st-order delta-sigma PDM bitstream
module pdm_tone_gen #(
    parameter int CLK_DIV = 6,
    parameter int WIDTH = 13,
    parameter int PHASE_W = 16,
    parameter int CHANNELS = 2,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CW-1:0]      cfg_ch,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [1:0]         cfg_wave,
    input  logic [3:0]         cfg_vol,
    output logic               cfg_ready,
    output logic               ce_out,
    output logic               pdm_out
);
    localparam int LC = $clog2(CHANNELS);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] cnt;
    logic ce;
    logic [PHASE_W-1:0] phase [CHANNELS];
    logic [PHASE_W-1:0] inc [CHANNELS];
    logic [PHASE_W-1:0] sh_inc [CHANNELS];
    logic [PHASE_W:0] step [CHANNELS];
    logic [1:0] wave [CHANNELS];
    logic [1:0] sh_wave [CHANNELS];
    logic [3:0] vol [CHANNELS];
    logic [3:0] sh_vol [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [WIDTH-1:0] smp [CHANNELS];
    logic [WIDTH-1:0] vsmp [CHANNELS];
    logic [WIDTH-1:0] mix;
    logic [WIDTH+LC-1:0] sum;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] acc_nxt;

    assign ce_out = ce;
    assign cfg_ready = !pending[cfg_ch];
    assign acc_nxt = {1'b0, acc[WIDTH-1:0]} + {1'b0, mix};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] p;
        logic [WIDTH+3:0] prod;
        assign p = phase[g][PHASE_W-1 -: WIDTH];
        assign smp[g] = wave[g] == 2'd0 ? p :
                        wave[g] == 2'd1 ? {WIDTH{p[WIDTH-1]}} :
                        wave[g] == 2'd2 ? (p[WIDTH-1] ? ~{p[WIDTH-2:0], 1'b0} : {p[WIDTH-2:0], 1'b0}) :
                        '0;
        assign prod = smp[g] * vol[g];
        assign vsmp[g] = prod[WIDTH+3:4];
        assign step[g] = {1'b0, phase[g]} + {1'b0, inc[g]};
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) sum = sum + (WIDTH+LC)'(vsmp[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ce <= 1'b0;
            pending <= '0;
            mix <= '0;
            acc <= '0;
            pdm_out <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                phase[i] <= '0;
                inc[i] <= '0;
                wave[i] <= 2'd3;
                vol[i] <= '0;
                sh_inc[i] <= '0;
                sh_wave[i] <= '0;
                sh_vol[i] <= '0;
            end
        end else begin
            ce <= cnt == DW'(CLK_DIV - 1);
            cnt <= cnt == DW'(CLK_DIV - 1) ? '0 : cnt + 1'b1;
            if (ce) begin
                mix <= WIDTH'(sum >> LC);
                acc <= acc_nxt;
                pdm_out <= acc_nxt[WIDTH];
                // shadow settings land only at a phase wrap (or while stopped) so the waveform never jumps
                for (int i = 0; i < CHANNELS; i++) begin
                    phase[i] <= step[i][PHASE_W-1:0];
                    if (pending[i] && (step[i][PHASE_W] || inc[i] == '0)) begin
                        inc[i] <= sh_inc[i];
                        wave[i] <= sh_wave[i];
                        vol[i] <= sh_vol[i];
                        pending[i] <= 1'b0;
                    end
                end
            end
            if (cfg_we && cfg_ready) begin
                sh_inc[cfg_ch] <= cfg_inc;
                sh_wave[cfg_ch] <= cfg_wave;
                sh_vol[cfg_ch] <= cfg_vol;
                pending[cfg_ch] <= 1'b1;
            end
        end
    end
endmodule

// File: doc/pdm_tone_gen.md
# pdm_tone_gen

Multi-channel tone synthesiser with a pulse-density-modulated 1-bit output for the Tang Nano 9K audio path. Each channel is a numerically controlled oscillator with selectable waveform and 4-bit volume. All channels are mixed into one unsigned sample that drives a 1st-order delta-sigma modulator. The block runs on the 27 MHz board clock with an internal clock-enable divider, and `pdm_out` drives the external RC filter pin.

## Interface
- `CLK_DIV`, 6: system clocks per sample tick; ≥ 2.
- `WIDTH`, 13: sample and modulator width.
- `PHASE_W`, 16: NCO phase and increment width; ≥ `WIDTH`.
- `CHANNELS`, 2: channel count; power of two, ≥ 1.
- `clk`  in  1  system clock, 27 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  config write strobe; accepted only when `cfg_ready`=1.
- `cfg_ch`  in  max(1,clog2(CHANNELS))  target channel.
- `cfg_inc`  in  PHASE_W  phase increment per tick.
- `cfg_wave`  in  2  waveform: 0 saw, 1 square, 2 triangle, 3 silence.
- `cfg_vol`  in  4  volume, 0..15.
- `cfg_ready`  out  1  high when `cfg_ch`'s shadow slot is free (combinational on `cfg_ch`).
- `ce_out`  out  1  sample-tick strobe, one `clk` wide.
- `pdm_out`  out  1  PDM bitstream, registered.

## Operation
- Divider: `cnt` counts 0..CLK_DIV-1. At the edge where `cnt`=CLK_DIV-1, `cnt`←0 and `ce`←1; on all other edges `ce`←0. `ce_out`=`ce`. All audio state advances only on edges where `ce`=1 (a "tick").
- Config: per channel, a live set {inc, wave, vol}, a shadow set, and a `pending` flag. `cfg_we` & `cfg_ready` writes the shadow set and sets `pending[cfg_ch]`. `cfg_ready` = !pending[cfg_ch]. A write while not ready is ignored with no side effects.
- NCO: on a tick, `phase`←(`phase`+`inc`) mod 2^PHASE_W. Wrap = carry-out of that add.
- Apply: on a tick where a channel wraps, or where its live `inc`=0, and `pending` is set: live←shadow and `pending`←0. The new inc takes effect on the next tick. The phase is never reset by an apply, so the output stays glitch-free.
- Waveform: p = phase[PHASE_W-1 -: WIDTH], m = p[WIDTH-1].
  - saw: s = p.
  - square: s = m ? 2^WIDTH-1 : 0.
  - triangle: s = m ? ~{p[WIDTH-2:0],0} : {p[WIDTH-2:0],0}.
  - silence: s = 0.
- Volume: v = (s × vol) >> 4, truncated to WIDTH bits.
- Mix: on a tick, `mix`←(Σ v over channels) >> log2(CHANNELS), using a WIDTH+log2(CHANNELS) wide sum. Channels use their pre-tick phase.
- Modulator: on a tick, `acc`←{0,acc[WIDTH-1:0]} + `mix` (pre-tick value), with WIDTH+1 bits. `pdm_out`←carry (bit WIDTH) of that sum, registered.
- Reset values:
  - `cnt`, `ce_out`, `pdm_out`, `acc`, `mix`, all phases, live inc, shadow regs and `pending` = 0.
  - Live wave = 3 (silence), vol = 0.
  - `cfg_ready`=1.
- Reset mid-operation: all of the above is restored on the next edge. Pending writes are discarded.

## Timing
- `ce_out` first goes high in the CLK_DIV-th cycle after `rst` deasserts, then repeats with period CLK_DIV cycles.
- Pipeline from phase to `pdm_out` is two ticks: phase at tick n → `mix` at tick n → `pdm_out` at tick n+1. `pdm_out` changes only on tick edges.
- A config write is visible in the shadow one `clk` later.
  - Apply happens on the first wrap tick (or first tick if live inc=0) after the write.
  - `cfg_ready` rises in the cycle after that tick.
  - Worst-case wait is 2^PHASE_W/inc ticks.
- A write to channel A never blocks a write to channel B.
- Sample rate at defaults = 4.5 MHz. Saw frequency = inc × 4.5 MHz / 65536.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release.
  - Required: `pdm_out`=0, `cfg_ready`=1, `ce_out` pulses at cycles 6, 12, 18, ….
  - Assert `rst` again mid-tone: `pdm_out` and phases read 0 on the next edge.
- **Immediate apply:** after reset, write ch0 {inc=0x0008, saw, vol=15}.
  - Required: applied on the first tick because live inc=0.
  - `cfg_ready` is low only from the write until the cycle after that tick.
  - Phase = 0x0008 after the second tick.
- **Square density:** ch0 {inc=0x0100, square, vol=15}, ch1 silent.
  - Required: mix = (8191×15>>4)>>1 = 3839 during the high half.
  - Ones count over any 8192 consecutive high-half ticks = 3839 (±1 window alignment). Ones = 0 in the low half once `acc` settles.
- **Glitch-free retune:** ch0 saw inc=0x0008. At phase 0x4000, write inc=0x0010.
  - Required: `cfg_ready` low. Phase keeps stepping by 8 until the wrap to 0x0000, then by 0x10.
  - A second write issued while `cfg_ready`=0 is ignored.
- **Two-channel mix:** ch0 and ch1 both square, inc=0x8000, vol=15, in phase.
  - Required: mix alternates 7679 and 0 each tick.
  - Write ch1 while ch0 is pending: it is accepted.
- **Triangle endpoints:** ch0 triangle, vol=15.
  - Required: s=0 at p=0; s=8190 at p=0x0FFF; s=8191 at p=0x1000.
